// File: rtl/ndma_pkg.sv
// Shared types and widths for the NanoDMA transfer sequencer.
package ndma_pkg;

   localparam int NDMA_ADDR_W = 32;
   localparam int NDMA_DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WR_ISSUE = 3'd3,
      WR_WAIT  = 3'd4,
      DONE     = 3'd5
   } xfer_state_t;

endpackage

// File: rtl/ndma_xfer_ctrl.sv
// Memory-to-memory word mover: one read, one write per word, one access in flight.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_i
// RD_ISSUE | waiting for read manager to go idle, then request read
// RD_WAIT  | read request sent (pulse visible here), waiting rd_valid_i
// WR_ISSUE | waiting for write manager to go idle, then request write
// WR_WAIT  | write request sent (pulse visible here), waiting wr_done_i
// DONE     | one-cycle completion pulse, busy_o already low
//
// Request pulses and their address/data are registered, so they appear in the
// first cycle of the matching WAIT state; a manager that answers in that same
// cycle gives the minimum of four cycles per word.
module ndma_xfer_ctrl
   import ndma_pkg::*;
#(
   parameter int LEN_W    = 16,
   parameter int ADDR_INC = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [NDMA_ADDR_W-1:0] src_addr_i,
   input  logic [NDMA_ADDR_W-1:0] dst_addr_i,
   input  logic [LEN_W-1:0]       len_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   aborted_o,
   output logic                   rd_req_o,
   output logic [NDMA_ADDR_W-1:0] rd_addr_o,
   input  logic                   rd_busy_i,
   input  logic                   rd_valid_i,
   input  logic [NDMA_DATA_W-1:0] rd_rdata_i,
   output logic                   wr_req_o,
   output logic [NDMA_ADDR_W-1:0] wr_addr_o,
   output logic [NDMA_DATA_W-1:0] wr_wdata_o,
   input  logic                   wr_busy_i,
   input  logic                   wr_done_i
);

   xfer_state_t            state_q, state_nxt;
   logic [NDMA_ADDR_W-1:0] src_q, dst_q;
   logic [LEN_W-1:0]       cnt_q;
   logic [NDMA_DATA_W-1:0] data_q;
   logic                   abort_q, aborted_q;
   logic                   rd_req_q, wr_req_q;
   logic [NDMA_ADDR_W-1:0] rd_addr_q, wr_addr_q;
   logic [NDMA_DATA_W-1:0] wr_wdata_q;

   logic load, step, capture, rd_fire, wr_fire, end_abort, abort_now, in_xfer;

   assign in_xfer   = (state_q == RD_ISSUE) || (state_q == RD_WAIT) ||
                      (state_q == WR_ISSUE) || (state_q == WR_WAIT);
   assign abort_now = abort_q | abort_i;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_nxt;
   end

   // Next-state and datapath control strobes.
   always_comb begin
      state_nxt = state_q;
      load      = 1'b0;
      step      = 1'b0;
      capture   = 1'b0;
      rd_fire   = 1'b0;
      wr_fire   = 1'b0;
      end_abort = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               load      = 1'b1;
               state_nxt = (len_i != '0) ? RD_ISSUE : DONE;
            end
         end
         RD_ISSUE: begin
            if (abort_now) begin
               end_abort = 1'b1;
               state_nxt = DONE;
            end else if (!rd_busy_i) begin
               rd_fire   = 1'b1;
               state_nxt = RD_WAIT;
            end
         end
         RD_WAIT: begin
            // An aborted read still has to land; its data is simply dropped.
            if (rd_valid_i) begin
               if (abort_now) begin
                  end_abort = 1'b1;
                  state_nxt = DONE;
               end else begin
                  capture   = 1'b1;
                  state_nxt = WR_ISSUE;
               end
            end
         end
         WR_ISSUE: begin
            if (abort_now) begin
               end_abort = 1'b1;
               state_nxt = DONE;
            end else if (!wr_busy_i) begin
               wr_fire   = 1'b1;
               state_nxt = WR_WAIT;
            end
         end
         WR_WAIT: begin
            if (wr_done_i) begin
               step = 1'b1;
               if (abort_now) begin
                  end_abort = 1'b1;
                  state_nxt = DONE;
               end else if (cnt_q == LEN_W'(1)) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = RD_ISSUE;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Address/count/data registers, abort tracking and registered request outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_q      <= '0;
         dst_q      <= '0;
         cnt_q      <= '0;
         data_q     <= '0;
         abort_q    <= 1'b0;
         aborted_q  <= 1'b0;
         rd_req_q   <= 1'b0;
         rd_addr_q  <= '0;
         wr_req_q   <= 1'b0;
         wr_addr_q  <= '0;
         wr_wdata_q <= '0;
      end else begin
         rd_req_q   <= rd_fire;
         rd_addr_q  <= rd_fire ? src_q : '0;
         wr_req_q   <= wr_fire;
         wr_addr_q  <= wr_fire ? dst_q : '0;
         wr_wdata_q <= wr_fire ? data_q : '0;
         if (load) begin
            src_q     <= src_addr_i;
            dst_q     <= dst_addr_i;
            cnt_q     <= len_i;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
         end else begin
            if (step) begin
               src_q <= src_q + NDMA_ADDR_W'(ADDR_INC);
               dst_q <= dst_q + NDMA_ADDR_W'(ADDR_INC);
               cnt_q <= cnt_q - LEN_W'(1);
            end
            if (capture) data_q <= rd_rdata_i;
            if (in_xfer && abort_i) abort_q <= 1'b1;
            else if (state_q == DONE) abort_q <= 1'b0;
            if (end_abort) aborted_q <= 1'b1;
         end
      end
   end

   assign busy_o     = in_xfer;
   assign done_o     = (state_q == DONE);
   assign aborted_o  = aborted_q;
   assign rd_req_o   = rd_req_q;
   assign rd_addr_o  = rd_addr_q;
   assign wr_req_o   = wr_req_q;
   assign wr_addr_o  = wr_addr_q;
   assign wr_wdata_o = wr_wdata_q;

endmodule

// File: tb/tb_ndma_xfer_ctrl.sv
// Bench for ndma_xfer_ctrl: bench-side read/write managers with a word memory,
// reference expectations computed from transfer parameters.
module tb_ndma_xfer_ctrl;

   localparam int LEN_W    = 16;
   localparam int ADDR_INC = 4;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             start_i = 1'b0, abort_i = 1'b0;
   logic [31:0]      src_addr_i = '0, dst_addr_i = '0;
   logic [LEN_W-1:0] len_i = '0;
   logic             busy_o, done_o, aborted_o;
   logic             rd_req_o, wr_req_o;
   logic [31:0]      rd_addr_o, wr_addr_o, wr_wdata_o;
   logic             rd_busy_i = 1'b0, rd_valid_i = 1'b0;
   logic [31:0]      rd_rdata_i = '0;
   logic             wr_busy_i = 1'b0, wr_done_i = 1'b0;

   ndma_xfer_ctrl #(.LEN_W(LEN_W), .ADDR_INC(ADDR_INC)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
      .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
      .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
      .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_busy_i(rd_busy_i),
      .rd_valid_i(rd_valid_i), .rd_rdata_i(rd_rdata_i),
      .wr_req_o(wr_req_o), .wr_addr_o(wr_addr_o), .wr_wdata_o(wr_wdata_o),
      .wr_busy_i(wr_busy_i), .wr_done_i(wr_done_i)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [31:0] rd_log[$];
   logic [31:0] wr_addr_log[$];
   logic [31:0] wr_data_log[$];
   int          cyc = 0, done_cnt = 0, busy_cnt = 0, done_lat = 0, idle_addr_err = 0;
   bit          rd_pend = 0, wr_pend = 0, rnd_mode = 0;
   int          rd_lat = 0, wr_lat = 0, max_lat = 3;
   logic [31:0] rd_hold_data = '0, salt = '0;
   int          abort_at = 0, abort_cyc = -1, rd_busy_hold = 0;
   int          rd_drop_cyc = -1, first_req_cyc = -1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ salt;
   endfunction

   // One clock: observe DUT outputs at the falling edge, then drive manager inputs.
   task automatic tick();
      @(negedge clk_i);
      cyc++;
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
      if (!rd_req_o && rd_addr_o != '0) idle_addr_err++;
      if (!wr_req_o && (wr_addr_o != '0 || wr_wdata_o != '0)) idle_addr_err++;
      abort_i = 1'b0;
      if (rd_req_o) begin
         rd_log.push_back(rd_addr_o);
         if (first_req_cyc < 0) first_req_cyc = cyc;
         rd_pend      = 1;
         rd_lat       = rnd_mode ? int'($urandom_range(0, max_lat)) : 0;
         rd_hold_data = mem_word(rd_addr_o);
         if (abort_at != 0 && rd_log.size() == abort_at) abort_i = 1'b1;
      end
      if (wr_req_o) begin
         wr_addr_log.push_back(wr_addr_o);
         wr_data_log.push_back(wr_wdata_o);
         wr_pend = 1;
         wr_lat  = rnd_mode ? int'($urandom_range(0, max_lat)) : 0;
      end
      if (cyc == abort_cyc) abort_i = 1'b1;
      rd_valid_i = 1'b0;
      rd_rdata_i = $urandom;
      if (rd_pend) begin
         if (rd_lat == 0) begin rd_valid_i = 1'b1; rd_rdata_i = rd_hold_data; rd_pend = 0; end
         else rd_lat--;
      end else if (rnd_mode) rd_valid_i = ($urandom_range(0, 7) == 0);
      wr_done_i = 1'b0;
      if (wr_pend) begin
         if (wr_lat == 0) begin wr_done_i = 1'b1; wr_pend = 0; end
         else wr_lat--;
      end else if (rnd_mode) wr_done_i = ($urandom_range(0, 7) == 0);
      if (rd_busy_hold > 0) begin
         rd_busy_i = 1'b1;
         rd_busy_hold--;
      end else begin
         if (rd_busy_i && rd_drop_cyc < 0) rd_drop_cyc = cyc;
         rd_busy_i = rnd_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      wr_busy_i  = rnd_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
      start_i    = 1'b0;
      src_addr_i = $urandom;
      dst_addr_i = $urandom;
      len_i      = LEN_W'($urandom);
      if (rnd_mode && busy_o && $urandom_range(0, 7) == 0) start_i = 1'b1;
      if (rnd_mode && !busy_o && $urandom_range(0, 3) == 0) abort_i = 1'b1;
   endtask

   // Start one transfer, wait for done_o, compare against the expected access lists.
   task automatic run_xfer(input string nm, input logic [31:0] src, input logic [31:0] dst,
                           input int len, input int abort_k, input int abort_rel,
                           input int exp_rd, input int exp_wr, input bit exp_abt,
                           input int exp_busy);
      int n, budget;
      logic [31:0] ea;
      rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
      done_cnt = 0; busy_cnt = 0; idle_addr_err = 0;
      first_req_cyc = -1; rd_drop_cyc = -1;
      abort_at  = abort_k;
      abort_cyc = (abort_rel >= 0) ? cyc + abort_rel : -1;
      salt      = $urandom;
      src_addr_i = src; dst_addr_i = dst; len_i = LEN_W'(len); start_i = 1'b1;
      tick();
      check_val({nm, ".abt_clr"}, 64'(aborted_o), 64'(0));
      n = 0;
      budget = 60 * len + 20;
      while (!done_o && n < budget) begin tick(); n++; end
      done_lat = n;
      check_val({nm, ".done_seen"}, 64'(done_o), 64'(1));
      check_val({nm, ".aborted"}, 64'(aborted_o), 64'(exp_abt));
      check_val({nm, ".busy_at_done"}, 64'(busy_o), 64'(0));
      tick();
      check_val({nm, ".done_pulses"}, 64'(done_cnt), 64'(1));
      check_val({nm, ".n_rd"}, 64'(rd_log.size()), 64'(exp_rd));
      check_val({nm, ".n_wr"}, 64'(wr_addr_log.size()), 64'(exp_wr));
      check_val({nm, ".idle_addr"}, 64'(idle_addr_err), 64'(0));
      for (int i = 0; i < rd_log.size() && i < exp_rd; i++) begin
         ea = src + 32'(ADDR_INC * i);
         check_val({nm, ".rd_addr"}, 64'(rd_log[i]), 64'(ea));
      end
      for (int i = 0; i < wr_addr_log.size() && i < exp_wr; i++) begin
         ea = dst + 32'(ADDR_INC * i);
         check_val({nm, ".wr_addr"}, 64'(wr_addr_log[i]), 64'(ea));
         ea = mem_word(src + 32'(ADDR_INC * i));
         check_val({nm, ".wr_data"}, 64'(wr_data_log[i]), 64'(ea));
      end
      if (exp_busy >= 0) check_val({nm, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
      abort_at = 0; abort_cyc = -1; rd_busy_hold = 0; rd_busy_i = 1'b0;
   endtask

   initial begin
      int n, len, k, erd, ewr;
      logic [31:0] s, d;
      repeat (2) @(negedge clk_i);
      #1;
      check_val("rst.ctl", 64'({busy_o, done_o, aborted_o, rd_req_o, wr_req_o}), 64'(0));
      check_val("rst.rd_addr", 64'(rd_addr_o), 64'(0));
      check_val("rst.wr_bus", 64'({wr_addr_o, wr_wdata_o}), 64'(0));
      rst_ni = 1'b1;
      tick();

      run_xfer("basic3", 32'h100, 32'h200, 3, 0, -1, 3, 3, 0, 12);

      run_xfer("len0", 32'h300, 32'h400, 0, 0, -1, 0, 0, 0, 0);
      check_val("len0.lat", 64'(done_lat), 64'(0));

      rd_busy_i = 1'b1; rd_busy_hold = 5;
      run_xfer("rdbusy", 32'h1000, 32'h2000, 2, 0, -1, 2, 2, 0, -1);
      check_val("rdbusy.req_cyc", 64'(first_req_cyc), 64'(rd_drop_cyc + 1));

      run_xfer("abort_rw2", 32'h40, 32'h80, 4, 2, -1, 2, 1, 1, -1);

      rd_busy_i = 1'b1; rd_busy_hold = 3;
      run_xfer("abort_iss", 32'h500, 32'h600, 3, 0, 1, 0, 0, 1, -1);
      check_val("abort_iss.lat", 64'(done_lat), 64'(1));

      run_xfer("wrap", 32'hFFFF_FFFC, 32'h10, 2, 0, -1, 2, 2, 0, 8);
      check_val("wrap.rd1", 64'((rd_log.size() > 1) ? rd_log[1] : 32'hDEAD_BEEF), 64'(0));

      // Reset while a write is in flight.
      rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
      src_addr_i = 32'h700; dst_addr_i = 32'h800; len_i = LEN_W'(4); start_i = 1'b1;
      tick();
      n = 0;
      while (!wr_req_o && n < 20) begin tick(); n++; end
      check_val("rstmid.reach", 64'(wr_req_o), 64'(1));
      rst_ni = 1'b0;
      #1;
      check_val("rstmid.ctl", 64'({busy_o, done_o, aborted_o, rd_req_o, wr_req_o}), 64'(0));
      check_val("rstmid.wr_bus", 64'({wr_addr_o, wr_wdata_o}), 64'(0));
      rd_pend = 0; wr_pend = 0;
      rd_valid_i = 1'b0; wr_done_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check_val("rstmid.hold", 64'({busy_o, done_o}), 64'(0));
      rst_ni = 1'b1;
      tick();
      run_xfer("after_rst", 32'h900, 32'hA00, 3, 0, -1, 3, 3, 0, 12);

      rnd_mode = 1;
      for (int it = 0; it < 40; it++) begin
         len = $urandom_range(0, 12);
         s   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & ~32'h3);
         d   = $urandom & ~32'h3;
         k   = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
         erd = (k != 0) ? k : len;
         ewr = (k != 0) ? k - 1 : len;
         run_xfer("rnd", s, d, len, k, -1, erd, ewr, (k != 0), -1);
      end
      rnd_mode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
